instr_encoder: RTL

Assembles RV32I ALU instruction words (R-type opcode 0110011, I-type opcode 0010011) from decoded field inputs. It is the producer-side counterpart of the pipeline's main decoder: bench sequencers and the self-test program generator drive it to create instruction streams, and its sideband control bits let checkers compare against the decoder.

A 2-entry registered skid buffer provides a valid/ready handshake on both sides. Illegal field combinations are rejected and counted, and accepted words are counted as they are delivered.

---
 rtl/instr_encoder.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
`timescale 1ns/1ps
// instr_encoder: builds RV32I ALU instruction words (R-type / I-type) from
// decoded fields, rejects illegal field combinations and delivers accepted
// words through a 2-entry registered skid buffer. A companion sideband
// (rs2/imm select, register write enable) mirrors what the main decoder is
// expected to produce for the head word.
module instr_encoder (
  input  logic        clk,
  input  logic        rst,
  // producer side
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_kind,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic        in_alt,
  input  logic [11:0] in_imm,
  // consumer side
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_rs2_imm_sel,
  output logic        out_reg_w_en,
  // status
  output logic        out_err,
  output logic [15:0] instr_cnt,
  output logic [7:0]  err_cnt
);

  localparam logic [6:0] OPC_R_TYPE  = 7'b0110011;
  localparam logic [6:0] OPC_I_TYPE  = 7'b0010011;
  localparam logic       KIND_R      = 1'b0;
  localparam logic [2:0] F3_ADD_SUB  = 3'b000;
  localparam logic [2:0] F3_SLL      = 3'b001;
  localparam logic [2:0] F3_SRL_SRA  = 3'b101;
  localparam logic [6:0] SHAMT_HI_L  = 7'b0000000;
  localparam logic [6:0] SHAMT_HI_A  = 7'b0100000;
  localparam logic [1:0] CNT_EMPTY   = 2'd0;
  localparam logic [1:0] CNT_FULL    = 2'd2;
  localparam int         DEPTH       = 2;

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  logic [31:0] word_mem [0:DEPTH-1];   // encoded words
  logic        sel_mem  [0:DEPTH-1];   // rs2/imm select per entry (1 = I-type)
  logic        head_reg;
  logic        tail_reg;
  logic [1:0]  count_reg;
  logic [1:0]  count_next;
  logic        in_ready_reg;
  logic        err_reg;
  logic [15:0] instr_cnt_reg;
  logic [7:0]  err_cnt_reg;

  // ------------------------------------------------------------------
  // Combinational helpers
  // ------------------------------------------------------------------
  logic        in_fire;
  logic        out_fire;
  logic        legal;
  logic        push;
  logic        pop;
  logic [31:0] enc_word;
  logic [DEPTH-1:0] wr_en;

  assign in_fire  = in_valid & in_ready_reg;
  assign out_fire = out_valid & out_ready;
  assign push     = in_fire & legal;
  assign pop      = out_fire;

  // Reject field combinations that have no RV32I encoding.
  always_comb begin
    legal = 1'b1;
    if (in_kind == KIND_R) begin
      // bit 30 only selects SUB (funct3 000) or SRA (funct3 101)
      if (in_alt && (in_funct3 != F3_ADD_SUB) && (in_funct3 != F3_SRL_SRA)) begin
        legal = 1'b0;
      end
    end else begin
      // shift-immediates carry a 5-bit shamt; upper bits are fixed
      if ((in_funct3 == F3_SLL) && (in_imm[11:5] != SHAMT_HI_L)) begin
        legal = 1'b0;
      end
      if ((in_funct3 == F3_SRL_SRA) &&
          (in_imm[11:5] != SHAMT_HI_L) && (in_imm[11:5] != SHAMT_HI_A)) begin
        legal = 1'b0;
      end
    end
  end

  // Assemble the instruction word for the presented fields.
  always_comb begin
    enc_word = 32'd0;
    if (in_kind == KIND_R) begin
      enc_word = {1'b0, in_alt, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, OPC_R_TYPE};
    end else begin
      enc_word = {in_imm, in_rs1, in_funct3, in_rd, OPC_I_TYPE};
    end
  end

  // Next occupancy; a push and a pop in the same cycle cancel out.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  // Per-entry write enables: only the tail slot is written on a push.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push && (tail_reg == 1'(gi));
    end
  endgenerate

  // ------------------------------------------------------------------
  // Sequential logic
  // ------------------------------------------------------------------

  // Entry storage; cleared on reset so the head reads as zero when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        word_mem[i] <= 32'd0;
        sel_mem[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          word_mem[i] <= enc_word;
          sel_mem[i]  <= in_kind;
        end
      end
    end
  end

  // Pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg     <= 1'b0;
      tail_reg     <= 1'b0;
      count_reg    <= CNT_EMPTY;
      in_ready_reg <= 1'b1;
    end else begin
      if (push) begin
        tail_reg <= ~tail_reg;
      end
      if (pop) begin
        head_reg <= ~head_reg;
      end
      count_reg    <= count_next;
      // ready is taken from next-state occupancy so it never depends
      // combinationally on out_ready
      in_ready_reg <= (count_next != CNT_FULL);
    end
  end

  // One-cycle error pulse for each rejected input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= in_fire & ~legal;
    end
  end

  // Delivered-word counter; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_cnt_reg <= 16'd0;
    end else if (pop) begin
      instr_cnt_reg <= instr_cnt_reg + 16'd1;
    end
  end

  // Rejected-input counter; sticks at its maximum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_reg <= 8'd0;
    end else if (in_fire && !legal && (err_cnt_reg != 8'hFF)) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign in_ready        = in_ready_reg;
  assign out_valid       = (count_reg != CNT_EMPTY);
  assign out_instr       = word_mem[head_reg];
  assign out_rs2_imm_sel = sel_mem[head_reg];
  assign out_reg_w_en    = out_valid;
  assign out_err         = err_reg;
  assign instr_cnt       = instr_cnt_reg;
  assign err_cnt         = err_cnt_reg;

endmodule
